fib_request_sequencer: RTL and testbench



---
 rtl/fib_request_sequencer.sv | 164 ++++++++++++++++
 tb/tb_fib_request_sequencer.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fib_request_sequencer.sv
// Request front-end for the Fibonacci control unit: queues indices, launches one
// computation at a time, and returns each result (or a timeout abort) over valid/ready.
module fib_request_sequencer #(
    parameter int unsigned N_WIDTH   = 5,
    parameter int unsigned RES_WIDTH = 32,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned TIMEOUT   = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [N_WIDTH-1:0]       req_n,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [N_WIDTH-1:0]       rsp_n,
    output logic [RES_WIDTH-1:0]     rsp_value,
    output logic                     rsp_timeout,
    output logic                     go,
    output logic [N_WIDTH-1:0]       count_to,
    input  logic                     done,
    input  logic [RES_WIDTH-1:0]     fib_value,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   req_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned TMR_W = $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT,
        ST_RESP,
        ST_DRAIN
    } state_t;

    state_t state, state_next;

    logic [N_WIDTH-1:0] fifo_mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               full, empty, push, pop;

    logic [TMR_W-1:0]     timer, timer_next;
    logic [N_WIDTH-1:0]   count_to_next, rsp_n_next;
    logic [RES_WIDTH-1:0] rsp_value_next;
    logic                 rsp_valid_next, rsp_timeout_next;

    // req_ready comes from the registered count only, so a full FIFO refuses
    // a push even in the cycle it is being popped.
    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);
    assign req_ready = !full;
    assign push      = req_valid && !full;
    assign pop       = (state == ST_IDLE) && !empty;
    assign req_count = count;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= req_n;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            timer       <= '0;
            count_to    <= '0;
            rsp_n       <= '0;
            rsp_value   <= '0;
            rsp_valid   <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            state       <= state_next;
            timer       <= timer_next;
            count_to    <= count_to_next;
            rsp_n       <= rsp_n_next;
            rsp_value   <= rsp_value_next;
            rsp_valid   <= rsp_valid_next;
            rsp_timeout <= rsp_timeout_next;
        end
    end

    always_comb begin
        state_next       = state;
        timer_next       = timer;
        count_to_next    = count_to;
        rsp_n_next       = rsp_n;
        rsp_value_next   = rsp_value;
        rsp_valid_next   = rsp_valid;
        rsp_timeout_next = rsp_timeout;
        go               = 1'b0;
        busy             = (state != ST_IDLE);

        unique case (state)
            ST_IDLE: begin
                if (!empty) begin
                    count_to_next = fifo_mem[rd_ptr];
                    rsp_n_next    = fifo_mem[rd_ptr];
                    state_next    = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                go         = 1'b1;
                timer_next = '0;
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                timer_next = timer + TMR_W'(1);
                // done has priority over a timeout expiring in the same cycle
                if (done) begin
                    rsp_value_next   = fib_value;
                    rsp_timeout_next = 1'b0;
                    rsp_valid_next   = 1'b1;
                    state_next       = ST_RESP;
                end else if (timer == TMR_W'(TIMEOUT - 1)) begin
                    rsp_value_next   = '0;
                    rsp_timeout_next = 1'b1;
                    rsp_valid_next   = 1'b1;
                    state_next       = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_next = 1'b0;
                    state_next     = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // a long done must fall before the next launch, or it would
                // complete the following request instantly
                if (!done) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_fib_request_sequencer.sv
// Directed bench for fib_request_sequencer with a behavioural control-unit model
// whose done delay, hold length and enable are set per step.
module tb_fib_request_sequencer;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_n;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [4:0]  rsp_n;
    logic [31:0] rsp_value;
    logic        rsp_timeout;
    logic        go;
    logic [4:0]  count_to;
    logic        done;
    logic [31:0] fib_value;
    logic        busy;
    logic [2:0]  req_count;

    int checks = 0;
    int errors = 0;
    int go_count = 0;

    int         mdl_cnt = 0;
    int         mdl_delay = 12;
    int         mdl_hold = 1;
    bit         mdl_en = 1'b1;
    bit         mdl_active = 1'b0;
    logic [4:0] mdl_n = '0;

    fib_request_sequencer #(
        .N_WIDTH(5),
        .RES_WIDTH(32),
        .DEPTH(4),
        .TIMEOUT(64)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_n(req_n),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_n(rsp_n),
        .rsp_value(rsp_value),
        .rsp_timeout(rsp_timeout),
        .go(go),
        .count_to(count_to),
        .done(done),
        .fib_value(fib_value),
        .busy(busy),
        .req_count(req_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] fibf(input logic [4:0] n);
        logic [31:0] a, b, t;
        a = 32'd0;
        b = 32'd1;
        for (int i = 0; i < int'(n); i++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    // Control-unit model: sees go on the falling edge, raises done mdl_delay
    // cycles later and holds it for mdl_hold cycles.
    always @(negedge clk) begin
        if (reset || !mdl_en) begin
            mdl_active = 1'b0;
            done       = 1'b0;
            fib_value  = 32'hDEAD_BEEF;
        end else begin
            if (go) begin
                mdl_active = 1'b1;
                mdl_cnt    = 0;
                mdl_n      = count_to;
            end else if (mdl_active) begin
                mdl_cnt++;
            end
            if (mdl_active && mdl_cnt >= mdl_delay && mdl_cnt < mdl_delay + mdl_hold) begin
                done      = 1'b1;
                fib_value = fibf(mdl_n);
            end else begin
                done      = 1'b0;
                fib_value = 32'hDEAD_BEEF;
            end
            if (mdl_active && mdl_cnt >= mdl_delay + mdl_hold) begin
                mdl_active = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (go === 1'b1) begin
            go_count++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_rsp(input string tag, input int max_cycles);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (rsp_valid !== 1'b1 && n < max_cycles);
        check(tag, {63'd0, rsp_valid}, 64'd1);
    endtask

    task automatic check_rsp(input string tag, input logic [4:0] n, input logic [31:0] v, input logic t);
        check({tag, "_n"}, {59'd0, rsp_n}, {59'd0, n});
        check({tag, "_value"}, {32'd0, rsp_value}, {32'd0, v});
        check({tag, "_timeout"}, {63'd0, rsp_timeout}, {63'd0, t});
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, {63'd0, req_ready}, 64'd1);
        check({tag, "_req_count"}, {61'd0, req_count}, 64'd0);
        check({tag, "_go"}, {63'd0, go}, 64'd0);
        check({tag, "_count_to"}, {59'd0, count_to}, 64'd0);
        check({tag, "_rsp_valid"}, {63'd0, rsp_valid}, 64'd0);
        check({tag, "_rsp_n"}, {59'd0, rsp_n}, 64'd0);
        check({tag, "_rsp_value"}, {32'd0, rsp_value}, 64'd0);
        check({tag, "_rsp_timeout"}, {63'd0, rsp_timeout}, 64'd0);
        check({tag, "_busy"}, {63'd0, busy}, 64'd0);
    endtask

    initial begin
        int  g;
        bit  acc;
        bit  rsp_seen;
        logic [4:0]  exp_n   [5];
        logic [31:0] exp_val [5];

        reset     = 1'b1;
        req_valid = 1'b0;
        req_n     = '0;
        rsp_ready = 1'b1;
        repeat (3) tick();
        check_reset_outputs("por");
        reset = 1'b0;
        tick();

        // single request, done after 12 cycles
        mdl_delay = 12;
        mdl_hold  = 1;
        req_valid = 1'b1;
        req_n     = 5'd10;
        tick();
        req_valid = 1'b0;
        check("t1_go_after_push", {63'd0, go}, 64'd0);
        check("t1_count_after_push", {61'd0, req_count}, 64'd1);
        tick();
        check("t1_go_pulse", {63'd0, go}, 64'd1);
        check("t1_count_to_launch", {59'd0, count_to}, 64'd10);
        check("t1_busy", {63'd0, busy}, 64'd1);
        tick();
        check("t1_go_single", {63'd0, go}, 64'd0);
        wait_rsp("t1_rsp", 100);
        check_rsp("t1", 5'd10, 32'd55, 1'b0);
        check("t1_count_to_hold", {59'd0, count_to}, 64'd10);
        repeat (3) tick();
        check("t1_idle", {63'd0, busy}, 64'd0);
        check("t1_go_count", go_count, 64'd1);

        // fill the FIFO while the controller stalls
        mdl_delay = 40;
        g = go_count;
        req_valid = 1'b1;
        req_n = 5'd3;  tick();
        req_n = 5'd5;  tick();
        req_n = 5'd7;  tick();
        req_n = 5'd9;  tick();
        req_n = 5'd11; tick();
        check("t2_full_count", {61'd0, req_count}, 64'd4);
        check("t2_full_ready", {63'd0, req_ready}, 64'd0);
        req_n = 5'd12;
        repeat (3) tick();
        check("t2_refused_count", {61'd0, req_count}, 64'd4);
        check("t2_refused_ready", {63'd0, req_ready}, 64'd0);
        wait_rsp("t2_rsp0", 200);
        check_rsp("t2_r0", 5'd3, 32'd2, 1'b0);
        acc = 1'b0;
        for (int i = 0; i < 50 && !acc; i++) begin
            acc = req_ready;
            tick();
        end
        req_valid = 1'b0;
        check("t2_held_accepted", {63'd0, acc}, 64'd1);
        check("t2_refill_count", {61'd0, req_count}, 64'd4);
        exp_n   = '{5'd5, 5'd7, 5'd9, 5'd11, 5'd12};
        exp_val = '{32'd5, 32'd13, 32'd34, 32'd89, 32'd144};
        for (int i = 0; i < 5; i++) begin
            wait_rsp("t2_rsp", 200);
            check_rsp("t2_r", exp_n[i], exp_val[i], 1'b0);
        end
        repeat (3) tick();
        check("t2_go_count", go_count, g + 6);

        // consumer back-pressure for 20 cycles
        mdl_delay = 5;
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_n = 5'd6; tick();
        req_n = 5'd4; tick();
        req_valid = 1'b0;
        wait_rsp("t3_rsp", 100);
        check_rsp("t3_r0", 5'd6, 32'd8, 1'b0);
        g = go_count;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("t3_hold_valid", {63'd0, rsp_valid}, 64'd1);
            check("t3_hold_n", {59'd0, rsp_n}, 64'd6);
            check("t3_hold_value", {32'd0, rsp_value}, 64'd8);
            check("t3_no_go", {63'd0, go}, 64'd0);
        end
        check("t3_go_count_hold", go_count, g);
        rsp_ready = 1'b1;
        wait_rsp("t3_rsp1", 100);
        check_rsp("t3_r1", 5'd4, 32'd3, 1'b0);
        check("t3_go_count", go_count, g + 1);
        repeat (3) tick();

        // controller never answers: timeout after 64 WAIT cycles
        mdl_en    = 1'b0;
        mdl_delay = 3;
        req_valid = 1'b1;
        req_n = 5'd8; tick();
        req_n = 5'd2; tick();
        req_valid = 1'b0;
        check("t4_go", {63'd0, go}, 64'd1);
        check("t4_count_to", {59'd0, count_to}, 64'd8);
        repeat (64) tick();
        check("t4_not_yet", {63'd0, rsp_valid}, 64'd0);
        tick();
        check("t4_timeout_valid", {63'd0, rsp_valid}, 64'd1);
        check_rsp("t4_to", 5'd8, 32'd0, 1'b1);
        mdl_en = 1'b1;
        wait_rsp("t4_rsp_next", 100);
        check_rsp("t4_next", 5'd2, 32'd1, 1'b0);
        repeat (3) tick();

        // done held for three cycles
        mdl_delay = 4;
        mdl_hold  = 3;
        g = go_count;
        req_valid = 1'b1;
        req_n = 5'd7; tick();
        req_n = 5'd9; tick();
        req_valid = 1'b0;
        wait_rsp("t5_rsp", 100);
        check_rsp("t5_r0", 5'd7, 32'd13, 1'b0);
        tick();
        check("t5_no_go_1", {63'd0, go}, 64'd0);
        tick();
        check("t5_no_go_2", {63'd0, go}, 64'd0);
        check("t5_drain_busy", {63'd0, busy}, 64'd1);
        tick();
        check("t5_no_go_3", {63'd0, go}, 64'd0);
        check("t5_idle", {63'd0, busy}, 64'd0);
        tick();
        check("t5_go_next", {63'd0, go}, 64'd1);
        check("t5_count_to_next", {59'd0, count_to}, 64'd9);
        wait_rsp("t5_rsp1", 100);
        check_rsp("t5_r1", 5'd9, 32'd34, 1'b0);
        check("t5_go_count", go_count, g + 2);
        repeat (5) tick();

        // reset while waiting with two requests queued
        mdl_delay = 30;
        mdl_hold  = 1;
        req_valid = 1'b1;
        req_n = 5'd5; tick();
        req_n = 5'd6; tick();
        req_n = 5'd7; tick();
        req_valid = 1'b0;
        check("t6_queued", {61'd0, req_count}, 64'd2);
        check("t6_busy", {63'd0, busy}, 64'd1);
        reset = 1'b1;
        tick();
        check_reset_outputs("t6_rst");
        reset = 1'b0;
        g = go_count;
        rsp_seen = 1'b0;
        repeat (50) begin
            tick();
            if (rsp_valid === 1'b1) rsp_seen = 1'b1;
        end
        check("t6_no_go", go_count, g);
        check("t6_no_rsp", {63'd0, rsp_seen}, 64'd0);
        check("t6_empty", {61'd0, req_count}, 64'd0);
        mdl_delay = 3;
        req_valid = 1'b1;
        req_n = 5'd1;
        tick();
        req_valid = 1'b0;
        check("t6_go_after_push", {63'd0, go}, 64'd0);
        tick();
        check("t6_go_pulse", {63'd0, go}, 64'd1);
        check("t6_count_to", {59'd0, count_to}, 64'd1);
        wait_rsp("t6_rsp", 100);
        check_rsp("t6_r", 5'd1, 32'd1, 1'b0);
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
